opt_share_unpack: RTL and testbench

Receive-side unpacker for the 48-bit packed result word produced by the shared add/sub datapath. That word is {hi, mid, lo} = {add_res or sub_res, c±d, add_res}, with a sel tag. The block accepts one packed word per valid/ready handshake, holds it in a single-entry register, and serializes it as three W-bit fields on a downstream valid/ready stream. An optional consistency checker flags packed words that the add/sub datapath cannot legally produce.

---
 rtl/opt_share_unpack_if.sv | 34 +++
 rtl/opt_share_unpack.sv | 141 ++++++++++++++
 tb/tb_opt_share_unpack.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/opt_share_unpack_if.sv
// ---------------------------------------------------------------------------
// opt_share_unpack_if
//   Bundles both streams of the unpacker: the packed-word input stream
//   (in_*) and the serialized-field output stream (out_*).
//   Modports:
//     slave  - the unpacker: consumes in_*, produces out_* and in_ready
//     master - the environment: produces in_*, consumes out_*, drives out_ready
//   Parameter:
//     WIDTH  - field width W; the packed word is 3*W bits
// ---------------------------------------------------------------------------
interface opt_share_unpack_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3*WIDTH-1:0]   in_data;
  logic                 in_sel;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [1:0]           out_idx;
  logic                 out_sel;
  logic                 out_last;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_sel, out_last
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_sel, out_last
  );
endinterface

// File: rtl/opt_share_unpack.sv
// ---------------------------------------------------------------------------
// opt_share_unpack
//   Receive-side unpacker for the packed add/sub result word
//   {hi, mid, lo}. Accepts one word per valid/ready handshake into a
//   single-entry holding register and emits it as three WIDTH-bit fields
//   (lo, mid, hi) on a downstream valid/ready stream.
//
//   Ports:
//     clk  - clock, all state on rising edge
//     rst  - asynchronous active-high reset
//     bus  - opt_share_unpack_if.slave (in_* packed input, out_* fields)
//     err  - sticky consistency error (only when OPT_SHARE_UNPACK_CHECK_EN
//            is defined)
//
//   Build option:
//     OPT_SHARE_UNPACK_CHECK_EN - when defined, each accepted word is
//       checked against what the add/sub datapath can produce; violations
//       set err until reset. Fields are forwarded unchanged either way.
// ---------------------------------------------------------------------------
module opt_share_unpack #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  opt_share_unpack_if.slave  bus
`ifdef OPT_SHARE_UNPACK_CHECK_EN
  ,
  output logic               err
`endif
);

  typedef enum logic [1:0] {IDLE, S0, S1, S2} state_t;

  state_t               state_q, state_d;
  logic [3*WIDTH-1:0]   hold_q, hold_d;
  logic                 sel_q, sel_d;
  logic [WIDTH-1:0]     field [3];
  logic                 in_ready;
  logic                 accept;
  logic [WIDTH-1:0]     out_data;
  logic [1:0]           out_idx;
  logic                 out_last;

  // Split the held word into its three fields: 0=lo, 1=mid, 2=hi.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_field
      assign field[gi] = hold_q[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // A new word may enter when idle, or in the cycle the last field (hi)
  // leaves, which gives back-to-back words with no bubble. Held low
  // during reset so nothing is handshaken while the block is cleared.
  assign in_ready = ~rst & ((state_q == IDLE) | ((state_q == S2) & bus.out_ready));
  assign accept   = bus.in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    sel_d   = sel_q;
    if (accept) begin
      hold_d = bus.in_data;
      sel_d  = bus.in_sel;
    end
    case (state_q)
      IDLE:    if (accept) state_d = S0;
      S0:      if (bus.out_ready) state_d = S1;
      S1:      if (bus.out_ready) state_d = S2;
      S2:      if (bus.out_ready) state_d = accept ? S0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state, never on in_data directly.
  always_comb begin
    out_data = '0;
    out_idx  = 2'd0;
    out_last = 1'b0;
    case (state_q)
      S0: begin
        out_data = field[0];
        out_idx  = 2'd0;
      end
      S1: begin
        out_data = field[1];
        out_idx  = 2'd1;
      end
      S2: begin
        out_data = field[2];
        out_idx  = 2'd2;
        out_last = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q != IDLE);
  assign bus.out_data  = out_data;
  assign bus.out_idx   = out_idx;
  assign bus.out_sel   = sel_q;
  assign bus.out_last  = out_last;

`ifdef OPT_SHARE_UNPACK_CHECK_EN
  logic             err_q, err_d;
  logic [WIDTH-1:0] chk_lo, chk_hi;
  logic             violation;

  assign chk_lo = bus.in_data[WIDTH-1:0];
  assign chk_hi = bus.in_data[3*WIDTH-1:2*WIDTH];

  // Add form duplicates add_res into hi and lo. Sub form carries
  // add_res and sub_res, whose sum 2a is even, so their LSBs agree.
  assign violation = bus.in_sel ? (chk_hi[0] != chk_lo[0]) : (chk_hi != chk_lo);

  always_comb begin
    err_d = err_q | (accept & violation);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_opt_share_unpack.sv
// ---------------------------------------------------------------------------
// tb_opt_share_unpack
//   Directed self-checking bench for opt_share_unpack. Inputs are driven
//   1 time unit after the rising edge; outputs are sampled 1 time unit
//   after that, well away from the active edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_opt_share_unpack;

  localparam int W = 16;

  logic clk;
  logic rst;
`ifdef OPT_SHARE_UNPACK_CHECK_EN
  logic err;
`endif

  int n_checks;
  int n_errors;

  opt_share_unpack_if #(.WIDTH(W)) bus ();

  opt_share_unpack #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef OPT_SHARE_UNPACK_CHECK_EN
    ,
    .err (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic drive_word(input logic v, input logic s,
                            input logic [W-1:0] hi, input logic [W-1:0] mid,
                            input logic [W-1:0] lo);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = {hi, mid, lo};
  endtask

  task automatic expect_field(input string tag, input logic [W-1:0] d,
                              input logic [1:0] idx, input logic s, input logic last);
    check({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, ".data"},  64'(bus.out_data),  64'(d));
    check({tag, ".idx"},   64'(bus.out_idx),   64'(idx));
    check({tag, ".sel"},   64'(bus.out_sel),   64'(s));
    check({tag, ".last"},  64'(bus.out_last),  64'(last));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive_word(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);

    // ---------------- reset state ----------------
    tick();
    settle();
    check("rst.in_ready",  64'(bus.in_ready),  64'd0);
    check("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst.out_data",  64'(bus.out_data),  64'd0);
    check("rst.out_idx",   64'(bus.out_idx),   64'd0);
    check("rst.out_sel",   64'(bus.out_sel),   64'd0);
    check("rst.out_last",  64'(bus.out_last),  64'd0);
`ifdef OPT_SHARE_UNPACK_CHECK_EN
    check("rst.err", 64'(err), 64'd0);
`endif
    rst = 1'b0;

    // ---------------- single word, add form ----------------
    tick();
    drive_word(1'b1, 1'b0, 16'h0005, 16'h0007, 16'h0005);
    settle();
    check("w1.idle_ready", 64'(bus.in_ready), 64'd1);
    tick();
    drive_word(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    settle();
    expect_field("w1.lo", 16'h0005, 2'd0, 1'b0, 1'b0);
    check("w1.s0_ready", 64'(bus.in_ready), 64'd0);
    tick(); settle();
    expect_field("w1.mid", 16'h0007, 2'd1, 1'b0, 1'b0);
    tick(); settle();
    expect_field("w1.hi", 16'h0005, 2'd2, 1'b0, 1'b1);
    check("w1.s2_ready", 64'(bus.in_ready), 64'd1);
`ifdef OPT_SHARE_UNPACK_CHECK_EN
    check("w1.err", 64'(err), 64'd0);
`endif
    tick(); settle();
    check("w1.idle_valid", 64'(bus.out_valid), 64'd0);

    // ---------------- stall in S1 ----------------
    drive_word(1'b1, 1'b0, 16'h0033, 16'h0022, 16'h0033);
    tick();
    drive_word(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    settle();
    expect_field("st.lo", 16'h0033, 2'd0, 1'b0, 1'b0);
    tick();
    bus.out_ready = 1'b0;
    settle();
    expect_field("st.mid", 16'h0022, 2'd1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      check($sformatf("st.hold%0d.data", i), 64'(bus.out_data), 64'h0022);
      check($sformatf("st.hold%0d.idx", i),  64'(bus.out_idx),  64'd1);
      check($sformatf("st.hold%0d.valid", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("st.hold%0d.ready", i), 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    tick(); settle();
    expect_field("st.hi", 16'h0033, 2'd2, 1'b0, 1'b1);
    tick(); settle();
    check("st.idle_valid", 64'(bus.out_valid), 64'd0);

`ifdef OPT_SHARE_UNPACK_CHECK_EN
    // ---------------- consistency checker ----------------
    drive_word(1'b1, 1'b0, 16'h1234, 16'h0000, 16'h1235);
    tick();
    drive_word(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    settle();
    check("chk.bad_err", 64'(err), 64'd1);
    check("chk.bad_lo", 64'(bus.out_data), 64'h1235);
    tick(); tick(); settle();
    check("chk.bad_hi", 64'(bus.out_data), 64'h1234);
    // legal sub-form word: LSBs of hi and lo agree
    drive_word(1'b1, 1'b1, 16'h0003, 16'h5555, 16'h0001);
    tick();
    drive_word(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    settle();
    check("chk.sticky_err", 64'(err), 64'd1);
    tick(); tick(); tick(); settle();
    check("chk.sticky_err2", 64'(err), 64'd1);
`endif

    // ---------------- async reset mid-word ----------------
    drive_word(1'b1, 1'b0, 16'h0044, 16'h0055, 16'h0044);
    tick();
    drive_word(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    tick(); settle();
    expect_field("ar.mid", 16'h0055, 2'd1, 1'b0, 1'b0);
    rst = 1'b1;
    settle();
    check("ar.out_valid", 64'(bus.out_valid), 64'd0);
    check("ar.out_data",  64'(bus.out_data),  64'd0);
    check("ar.out_idx",   64'(bus.out_idx),   64'd0);
    check("ar.out_last",  64'(bus.out_last),  64'd0);
    check("ar.in_ready",  64'(bus.in_ready),  64'd0);
`ifdef OPT_SHARE_UNPACK_CHECK_EN
    check("ar.err", 64'(err), 64'd0);
`endif
    tick();
    rst = 1'b0;
    drive_word(1'b1, 1'b1, 16'h0066, 16'h0077, 16'h0066);
    tick();
    drive_word(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    settle();
    expect_field("ar.new_lo", 16'h0066, 2'd0, 1'b1, 1'b0);
    tick(); tick(); tick(); settle();
    check("ar.idle_valid", 64'(bus.out_valid), 64'd0);

    // ---------------- back-to-back, early in_valid ----------------
    drive_word(1'b1, 1'b1, 16'h0001, 16'h0002, 16'h0003);
    settle();
    check("bb.idle_ready", 64'(bus.in_ready), 64'd1);
    tick();
    drive_word(1'b1, 1'b0, 16'h000A, 16'h000B, 16'h000C);
    settle();
    expect_field("bb.a_lo", 16'h0003, 2'd0, 1'b1, 1'b0);
    check("bb.s0_ready", 64'(bus.in_ready), 64'd0);
    tick(); settle();
    expect_field("bb.a_mid", 16'h0002, 2'd1, 1'b1, 1'b0);
    check("bb.s1_ready", 64'(bus.in_ready), 64'd0);
    tick(); settle();
    expect_field("bb.a_hi", 16'h0001, 2'd2, 1'b1, 1'b1);
    check("bb.s2_ready", 64'(bus.in_ready), 64'd1);
    tick();
    drive_word(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    settle();
    expect_field("bb.b_lo", 16'h000C, 2'd0, 1'b0, 1'b0);
    check("bb.b_s0_ready", 64'(bus.in_ready), 64'd0);
    tick(); settle();
    expect_field("bb.b_mid", 16'h000B, 2'd1, 1'b0, 1'b0);
    tick(); settle();
    expect_field("bb.b_hi", 16'h000A, 2'd2, 1'b0, 1'b1);
    tick(); settle();
    check("bb.idle_valid", 64'(bus.out_valid), 64'd0);
    check("bb.idle_ready", 64'(bus.in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
